wb_arbiter: RTL and testbench

Register-file write-port arbiter for the rvseed core. It sits between the producers of writeback results (load return from MEM, multi-cycle mul/div unit, single-cycle EX result) and the single register-file write port, granting one requester per cycle. It applies the result extension (`expand_signed` encoding) and suppresses writes to x0. It also sequences an ebreak halt by draining outstanding writebacks before acknowledging.

---
 rtl/wb_arbiter_pkg.sv | 30 +++
 rtl/wb_ext_unit.sv | 25 ++
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
// Requester indices, FSM states and extension codes.
package wb_arbiter_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int NREQ = 3;

  localparam int REQ_MEM = 0;
  localparam int REQ_MDU = 1;
  localparam int REQ_EX  = 2;

  localparam logic [3:0] EXT_PASS = 4'd0;
  localparam logic [3:0] EXT_SW   = 4'd1;
  localparam logic [3:0] EXT_ZW   = 4'd2;
  localparam logic [3:0] EXT_SH   = 4'd3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } wb_state_e;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic [63:0]               wdata;
    logic [3:0]                ext;
  } wb_req_t;

endpackage

// File: rtl/wb_ext_unit.sv
// Result extension for the register-file write data.
// Codes above EXT_SH are accepted but never written.
module wb_ext_unit
  import wb_arbiter_pkg::*;
(
  input  logic [63:0] wdata,
  input  logic [3:0]  ext,
  output logic [63:0] xdata,
  output logic        write_ok
);

  // decode the extension code
  always_comb begin
    xdata    = wdata;
    write_ok = 1'b1;
    unique case (ext)
      EXT_PASS: xdata = wdata;
      EXT_SW:   xdata = {{32{wdata[31]}}, wdata[31:0]};
      EXT_ZW:   xdata = {32'h0, wdata[31:0]};
      EXT_SH:   xdata = {{48{wdata[15]}}, wdata[15:0]};
      default:  write_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter with starvation override
// and an ebreak drain/halt sequencer.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  input  logic                      mdu_valid,
  input  logic                      ex_valid,
  output logic                      mem_ready,
  output logic                      mdu_ready,
  output logic                      ex_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mem_waddr,
  input  logic [REG_ADDR_WIDTH-1:0] mdu_waddr,
  input  logic [REG_ADDR_WIDTH-1:0] ex_waddr,
  input  logic [63:0]               mem_wdata,
  input  logic [63:0]               mdu_wdata,
  input  logic [63:0]               ex_wdata,
  input  logic [3:0]                mem_ext,
  input  logic [3:0]                mdu_ext,
  input  logic [3:0]                ex_ext,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [63:0]               rf_wdata,
  input  logic                      halt_req,
  output logic                      halt_ack
);

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  wb_req_t         req [NREQ];
  wb_req_t         sel;
  wb_state_e       state;
  wb_state_e       state_nx;
  logic [2:0]      cnt [NREQ];
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] starve;
  logic [NREQ-1:0] grant;
  logic            xfer;
  logic [63:0]     xdata;
  logic            write_ok;

  assign req[REQ_MEM] = '{valid: mem_valid, waddr: mem_waddr,
                          wdata: mem_wdata, ext: mem_ext};
  assign req[REQ_MDU] = '{valid: mdu_valid, waddr: mdu_waddr,
                          wdata: mdu_wdata, ext: mdu_ext};
  assign req[REQ_EX]  = '{valid: ex_valid, waddr: ex_waddr,
                          wdata: ex_wdata, ext: ex_ext};

  // eligibility: ex is held off outside RUN, nobody in HALTED
  always_comb begin
    elig   = '0;
    starve = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i].valid && !rst && (state != HALTED)
             && !((i == REQ_EX) && (state != RUN));
      starve[i] = elig[i] && (cnt[i] == SMAX);
    end
  end

  // lowest-index starving requester first, else fixed priority
  always_comb begin
    grant = '0;
    if (|starve)
      grant = starve & (~starve + 3'd1);
    else
      grant = elig & (~elig + 3'd1);
  end

  assign mem_ready = grant[REQ_MEM];
  assign mdu_ready = grant[REQ_MDU];
  assign ex_ready  = grant[REQ_EX];
  assign xfer      = |grant;

  // route the granted request
  always_comb begin
    sel = '0;
    unique case (1'b1)
      grant[REQ_MEM]: sel = req[REQ_MEM];
      grant[REQ_MDU]: sel = req[REQ_MDU];
      grant[REQ_EX]:  sel = req[REQ_EX];
      default:        sel = '0;
    endcase
  end

  wb_ext_unit u_ext (
    .wdata    (sel.wdata),
    .ext      (sel.ext),
    .xdata    (xdata),
    .write_ok (write_ok)
  );

  // starvation counters: count denied cycles, saturate
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst)
        cnt[i] <= 3'd0;
      else if (req[i].valid && !grant[i])
        cnt[i] <= (cnt[i] == SMAX) ? cnt[i] : cnt[i] + 3'd1;
      else
        cnt[i] <= 3'd0;
    end
  end

  // halt sequencer state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nx;
  end

  // halt sequencer next state
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:
        if (halt_req)
          state_nx = DRAIN;
      DRAIN:
        if (!mem_valid && !mdu_valid && !xfer)
          state_nx = HALTED;
      HALTED:
        state_nx = HALTED;
      default:
        state_nx = RUN;
    endcase
  end

  // registered write port; x0 and bad codes never write
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (xfer) begin
      rf_wen   <= write_ok && (sel.waddr != '0);
      rf_waddr <= sel.waddr;
      rf_wdata <= xdata;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  assign halt_ack = (state == HALTED);

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against
// a cycle-level behavioural model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int SM = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      halt;
  logic                      v [3];
  logic [REG_ADDR_WIDTH-1:0] a [3];
  logic [63:0]               d [3];
  logic [3:0]                e [3];
  logic                      mem_ready, mdu_ready, ex_ready;
  logic                      rf_wen;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [63:0]               rf_wdata;
  logic                      halt_ack;

  int checks = 0;
  int errors = 0;

  int                        m_cnt [3];
  int                        m_st;
  logic                      m_wen;
  logic [REG_ADDR_WIDTH-1:0] m_waddr;
  logic [63:0]               m_wdata;
  bit                        m_known;
  int                        g;
  int                        dut_g;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (v[0]),
    .mdu_valid (v[1]),
    .ex_valid  (v[2]),
    .mem_ready (mem_ready),
    .mdu_ready (mdu_ready),
    .ex_ready  (ex_ready),
    .mem_waddr (a[0]),
    .mdu_waddr (a[1]),
    .ex_waddr  (a[2]),
    .mem_wdata (d[0]),
    .mdu_wdata (d[1]),
    .ex_wdata  (d[2]),
    .mem_ext   (e[0]),
    .mdu_ext   (e[1]),
    .ex_ext    (e[2]),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .halt_req  (halt),
    .halt_ack  (halt_ack)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ext_model(input logic [63:0] x,
                                            input logic [3:0] c);
    case (c)
      4'd0:    return x;
      4'd1:    return 64'($signed(x[31:0]));
      4'd2:    return x & 64'h0000_0000_FFFF_FFFF;
      4'd3:    return 64'($signed(x[15:0]));
      default: return x;
    endcase
  endfunction

  // winner by the written rules: 0 run, 1 drain, 2 halted
  function automatic int pick();
    bit ok [3];
    int best = -1;
    int hungry = -1;
    for (int i = 0; i < 3; i++)
      ok[i] = v[i] && !rst && m_st != 2 && !(i == 2 && m_st != 0);
    for (int i = 2; i >= 0; i--) begin
      if (ok[i]) best = i;
      if (ok[i] && m_cnt[i] == SM) hungry = i;
    end
    return (hungry >= 0) ? hungry : best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_st    = 0;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_known = 1'b1;
  endtask

  // one clock: check outputs mid-cycle, advance the model
  task automatic cycle();
    logic [2:0] rv;
    @(negedge clk);
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_waddr", rf_waddr, m_waddr);
    if (m_known) chk("rf_wdata", rf_wdata, m_wdata);
    chk("halt_ack", halt_ack, m_st == 2);
    g  = pick();
    rv = {ex_ready, mdu_ready, mem_ready};
    chk("ready", rv, (g < 0) ? 64'd0 : (64'd1 << g));
    dut_g = mem_ready ? 0 : mdu_ready ? 1 : ex_ready ? 2 : 3;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++)
        if (v[i] && g != i)
          m_cnt[i] = (m_cnt[i] + 1 > SM) ? SM : m_cnt[i] + 1;
        else
          m_cnt[i] = 0;
      if (g >= 0) begin
        m_wen   = (e[g] < 4) && (a[g] != 0);
        m_waddr = a[g];
        m_wdata = ext_model(d[g], e[g]);
        m_known = (e[g] < 4);
      end else begin
        m_wen = 1'b0;
      end
      if (m_st == 0 && halt)
        m_st = 1;
      else if (m_st == 1 && !v[0] && !v[1])
        m_st = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    halt = 1'b0;
    rst  = 1'b1;
    cycle();
    rst  = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [4:0] ad,
                         input logic [63:0] dt, input logic [3:0] ex);
    v[i] = 1'b1;
    a[i] = ad;
    d[i] = dt;
    e[i] = ex;
  endtask

  initial begin
    logic [11:0] seq;
    rst  = 1'b1;
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; a[i] = '0; d[i] = '0; e[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // reset state then sign-extended ex write
    set_req(2, 5'd5, 64'hFFFF_FFFF_8000_0000, 4'd1);
    cycle();
    chk("t1_grant", dut_g, 2);
    idle();
    chk("t1_wen", rf_wen, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 64'hFFFF_FFFF_8000_0000);
    cycle();

    // mem streaming against ex: ex must win on the 5th cycle
    do_reset();
    seq = '0;
    set_req(2, 5'd9, 64'h77, 4'd0);
    set_req(0, 5'd1, 64'h100, 4'd0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      seq = {seq[9:0], 2'(dut_g)};
      if (dut_g == 0) d[0] = d[0] + 64'd1;
      if (dut_g == 2) v[2] = 1'b0;
    end
    chk("starve_seq", seq, 12'h008);
    idle();
    cycle();

    // mdu extension codes
    set_req(1, 5'd7, 64'h1234_5678_9ABC_DEF0, 4'd2);
    cycle();
    chk("zw_data", rf_wdata, 64'h0000_0000_9ABC_DEF0);
    set_req(1, 5'd7, 64'h8001, 4'd3);
    cycle();
    chk("sh_data", rf_wdata, 64'hFFFF_FFFF_FFFF_8001);
    idle();

    // x0 and reserved code are accepted without a write
    set_req(2, 5'd0, 64'hDEAD, 4'd0);
    cycle();
    chk("x0_grant", dut_g, 2);
    chk("x0_wen", rf_wen, 0);
    set_req(2, 5'd3, 64'hBEEF, 4'd7);
    cycle();
    chk("bad_grant", dut_g, 2);
    chk("bad_wen", rf_wen, 0);
    idle();
    cycle();

    // halt drains mdu while ex waits
    do_reset();
    set_req(1, 5'd4, 64'h10, 4'd0);
    set_req(2, 5'd6, 64'h20, 4'd0);
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    chk("h_first", dut_g, 1);
    for (int k = 0; k < 3; k++) begin
      d[1] = d[1] + 64'd1;
      chk("h_ex_ready", ex_ready, 0);
      cycle();
      chk("h_ack_lo", halt_ack, 0);
    end
    chk("h_last_wen", rf_wen, 1);
    chk("h_last_data", rf_wdata, 64'h13);
    v[1] = 1'b0;
    cycle();
    chk("h_ack", halt_ack, 1);
    cycle();
    cycle();

    // reset in the middle of a drain transfer
    do_reset();
    set_req(1, 5'd8, 64'h55, 4'd0);
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    d[1] = 64'h66;
    rst  = 1'b1;
    cycle();
    rst  = 1'b0;
    chk("r_wen", rf_wen, 0);
    chk("r_wdata", rf_wdata, 0);
    chk("r_ack", halt_ack, 0);
    idle();
    set_req(2, 5'd2, 64'h99, 4'd0);
    cycle();
    chk("r_ex_grant", dut_g, 2);
    idle();
    cycle();

    // random traffic with occasional halts and resets
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom % 150) == 0;
      halt = ($urandom % 80) == 0;
      cycle();
      rst  = 1'b0;
      halt = 1'b0;
      for (int i = 0; i < 3; i++)
        if (!v[i] || g == i) begin
          v[i] = ($urandom % 3) != 0;
          a[i] = 5'($urandom % 32);
          d[i] = {$urandom, $urandom};
          e[i] = 4'($urandom % 6);
        end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
